caesar_sequencer: RTL and testbench
===================================

// Module: caesar_sequencer
// PURPOSE
//  Front-end controller for the Caesar-cipher datapath. Latches up to DEPTH keypad digits,
//  adds the shift key mod 10 to each, issues every shifted digit to the 5-bit digit encoder
//  over a req/ack handshake, and buffers the returned codes. It then scans the codes, one per
//  DWELL cycles, to the 7-segment display decoder. It sits between keypad/buttons and encoder+display.
// PARAMETERS
//  DEPTH    4      max message length in digits (>=1)
//  TIMEOUT  16     cycles to wait for enc_ack before substituting IDLE_CODE
//  DWELL    25e6   clk cycles each code is held on code_out in SHOW
// PORTS
//  clk         in   1   single system clock; all logic on posedge
//  reset       in   1   synchronous, active-low reset
//  digit       in   4   BCD digit from keypad, legal 0..9
//  ready       in   1   load button level; rising edge (detected internally) loads digit
//  key         in   4   shift amount, legal 0..9; sampled on start edge
//  start       in   1   button level; rising edge starts encryption / clears shown message
//  enc_req     out  1   one-cycle request to encoder
//  enc_digit   out  4   shifted digit, valid with enc_req
//  enc_ack     in   1   encoder result valid (>=1 cycle after enc_req)
//  enc_code    in   5   encoder result, sampled when enc_ack=1
//  code_out    out  5   current code to display decoder
//  code_valid  out  1   1 while in SHOW
//  busy        out  1   1 in ISSUE or WAIT
//  count       out  $clog2(DEPTH+1)  digits stored
//  err         out  1   sticky error flag, cleared only by reset
// BEHAVIOUR
//  Reset (reset=0 at posedge): state IDLE, count=0, idx=0, code_out=IDLE_CODE (5'b01010),
//   code_valid=0, enc_req=0, enc_digit=0, busy=0, err=0, timers=0; edge registers ready_q and
//   start_q load 1 so a button held through reset produces no edge.
//  Edges: rise = in & ~in_q, registered in_q; each edge counts once.
//  IDLE:  start edge, count>0, key<=9 -> key_q=key, idx=0, ISSUE (start has priority over a
//         same-cycle ready edge, which is dropped). start edge with key>9 -> err=1, stay.
//         start edge with count=0 -> ignored. ready edge: digit>9 or count==DEPTH -> err=1,
//         digit discarded; else buf[count]=digit, count++ (visible next cycle).
//  ISSUE: enc_req=1 for exactly this cycle; enc_digit=buf[idx]+key_q, minus 10 if >=10
//         (5-bit intermediate, result 0..9). Next: WAIT, timer cleared.
//  WAIT:  enc_ack -> res[idx]=enc_code. Timer reaching TIMEOUT with no ack -> res[idx]=IDLE_CODE,
//         err=1. Either way: idx==count-1 -> SHOW, idx=0, dwell cleared; else idx++, ISSUE.
//         enc_ack outside WAIT is ignored. Latency per digit: 1 + ack delay cycles.
//  SHOW:  code_out=res[idx], code_valid=1; after DWELL cycles idx wraps count-1 -> 0.
//         start edge -> IDLE, count=0, code_out=IDLE_CODE, code_valid=0. ready edges ignored.
//  ready/start edges in ISSUE/WAIT are ignored. key changes after start have no effect.
//  Outside SHOW code_out=IDLE_CODE. Reset mid-operation aborts immediately; buffers need
//   no clearing since count=0.
// STRUCTURE
//  caesar_pkg: state enum {IDLE,ISSUE,WAIT,SHOW}, IDLE_CODE=5'b01010, DIGIT_MAX=4'd9,
//   function add_mod10(d,k). Shared with the encoder/display wrappers.
//  Sub-module rise_detect (sync reset, reset value parameter) instantiated for ready and start.
//  Digit/code buffers are flop arrays indexed by count/idx; no RAM.
// TESTING  (bench encoder model: acks 2 cycles after enc_req with enc_code={1'b0,enc_digit}; DWELL=4)
//  1 reset=0 for 3 cycles with ready=1 held, release -> code_out=01010, count=0, no load.
//  2 load 1,2,7; key=5; start -> enc_digit 6,7,2 in order; SHOW code_out 00110,00111,00010
//    each 4 cycles, then wraps to 00110; err=0.
//  3 DEPTH=4, five ready edges with digit=3 -> count=4, err=1, 5th discarded.
//  4 digit=4'hC edge -> count unchanged, err=1; key=4'hA + start -> stays IDLE, busy=0.
//  5 model withholds ack for 2nd digit -> after 16 cycles res[1]=01010, 3rd digit issued, err=1.
//  6 reset=0 during WAIT -> next cycle IDLE, enc_req=0, count=0, code_out=01010; late ack ignored.

Source files
------------

// File: rtl/caesar_pkg.sv
// Shared types and constants for the Caesar-cipher front end, encoder and display wrappers.
package caesar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_e;

  localparam logic [4:0] IDLE_CODE = 5'b01010;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Shift a BCD digit by a BCD key, wrapping at 10.
  function automatic logic [3:0] add_mod10(input logic [3:0] d, input logic [3:0] k);
    logic [4:0] sum;
    sum = {1'b0, d} + {1'b0, k};
    if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a button level; the history flop resets to RST_VAL.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!reset) sig_q <= RST_VAL;
    else        sig_q <= sig_i;
  end

  assign rise_c = sig_i & ~sig_q;

endmodule

// File: rtl/caesar_sequencer.sv
// Latches keypad digits, shifts them by the key, runs them through the encoder
// handshake, then scans the returned codes to the display.
module caesar_sequencer
  import caesar_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DWELL   = 25_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   digit,
  input  logic                         ready,
  input  logic [3:0]                   key,
  input  logic                         start,
  output logic                         enc_req,
  output logic [3:0]                   enc_digit,
  input  logic                         enc_ack,
  input  logic [4:0]                   enc_code,
  output logic [4:0]                   code_out,
  output logic                         code_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DWL_W = $clog2(DWELL + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           key_q, key_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [DWL_W-1:0]     dwell_q, dwell_d;
  logic                 err_q, err_d;
  logic                 enc_req_q, enc_req_d;
  logic [3:0]           enc_digit_q, enc_digit_d;
  logic [4:0]           code_out_q, code_out_d;
  logic                 code_valid_q, code_valid_d;
  logic                 busy_q, busy_d;
  logic [3:0]           buf_q [DEPTH];
  logic [3:0]           buf_d [DEPTH];
  logic [4:0]           res_q [DEPTH];
  logic [4:0]           res_d [DEPTH];

  logic ready_rise_c, start_rise_c;
  logic last_c, wait_done_c;

  // History flops load 1 so a button held through reset yields no edge.
  rise_detect #(.RST_VAL(1'b1)) u_ready_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (ready),
    .rise_c (ready_rise_c)
  );

  rise_detect #(.RST_VAL(1'b1)) u_start_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (start),
    .rise_c (start_rise_c)
  );

  assign last_c = ((CNT_W'(idx_q) + CNT_W'(1)) == count_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    key_d       = key_q;
    timer_d     = timer_q;
    dwell_d     = dwell_q;
    err_d       = err_q;
    buf_d       = buf_q;
    res_d       = res_q;
    wait_done_c = 1'b0;

    case (state_q)
      IDLE: begin
        // A start edge always wins; a same-cycle ready edge is dropped.
        if (start_rise_c) begin
          if (key > DIGIT_MAX) begin
            err_d = 1'b1;
          end else if (count_q != '0) begin
            key_d   = key;
            idx_d   = '0;
            state_d = ISSUE;
          end
        end else if (ready_rise_c) begin
          if ((digit > DIGIT_MAX) || (count_q == CNT_W'(DEPTH))) begin
            err_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (CNT_W'(i) == count_q) buf_d[i] = digit;
            end
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (enc_ack) begin
          res_d[idx_q] = enc_code;
          wait_done_c  = 1'b1;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          res_d[idx_q] = IDLE_CODE;
          err_d        = 1'b1;
          wait_done_c  = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (wait_done_c) begin
          if (last_c) begin
            idx_d   = '0;
            dwell_d = '0;
            state_d = SHOW;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end

      SHOW: begin
        if (start_rise_c) begin
          count_d = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (dwell_q == DWL_W'(DWELL - 1)) begin
          dwell_d = '0;
          idx_d   = last_c ? '0 : idx_q + IDX_W'(1);
        end else begin
          dwell_d = dwell_q + DWL_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered against the next state so they line up with it.
    enc_req_d    = (state_d == ISSUE);
    enc_digit_d  = (state_d == ISSUE) ? add_mod10(buf_d[idx_d], key_d) : enc_digit_q;
    busy_d       = (state_d == ISSUE) || (state_d == WAIT);
    code_valid_d = (state_d == SHOW);
    code_out_d   = (state_d == SHOW) ? res_d[idx_d] : IDLE_CODE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      key_q        <= '0;
      timer_q      <= '0;
      dwell_q      <= '0;
      err_q        <= 1'b0;
      enc_req_q    <= 1'b0;
      enc_digit_q  <= '0;
      code_out_q   <= IDLE_CODE;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      timer_q      <= timer_d;
      dwell_q      <= dwell_d;
      err_q        <= err_d;
      enc_req_q    <= enc_req_d;
      enc_digit_q  <= enc_digit_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Buffers are qualified by count, so they carry no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    res_q <= res_d;
  end

  assign enc_req    = enc_req_q;
  assign enc_digit  = enc_digit_q;
  assign code_out   = code_out_q;
  assign code_valid = code_valid_q;
  assign busy       = busy_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_caesar_sequencer.sv
// Directed bench for caesar_sequencer with a 2-cycle-ack encoder model and DWELL=4.
module tb_caesar_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DWELL   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit;
  logic       ready;
  logic [3:0] key;
  logic       start;
  logic       enc_req;
  logic [3:0] enc_digit;
  logic       enc_ack;
  logic [4:0] enc_code;
  logic [4:0] code_out;
  logic       code_valid;
  logic       busy;
  logic [2:0] count;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  int         cyc = 0;
  int         dly = 0;
  int         req_num = 0;
  int         drop_n = 0;
  logic [3:0] dig_q [$];
  int         req_cyc [$];

  caesar_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DWELL(DWELL)) dut (
    .clk        (clk),
    .reset      (reset),
    .digit      (digit),
    .ready      (ready),
    .key        (key),
    .start      (start),
    .enc_req    (enc_req),
    .enc_digit  (enc_digit),
    .enc_ack    (enc_ack),
    .enc_code   (enc_code),
    .code_out   (code_out),
    .code_valid (code_valid),
    .busy       (busy),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Encoder model: ack two edges after the request, code = {0, digit}; request drop_n gets no ack.
  always @(negedge clk) begin
    enc_ack = 1'b0;
    if (dly == 1) enc_ack = 1'b1;
    if (dly != 0) dly = dly - 1;
    if (enc_req === 1'b1) begin
      req_num = req_num + 1;
      dig_q.push_back(enc_digit);
      req_cyc.push_back(cyc);
      enc_code = {1'b0, enc_digit};
      if (req_num != drop_n) dly = 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
    dig_q.delete();
    req_cyc.delete();
    req_num = 0;
    drop_n  = 0;
  endtask

  task automatic press_ready(input logic [3:0] d);
    digit = d;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_start(input logic [3:0] k);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = 4'd0;
    @(negedge clk);
  endtask

  task automatic wait_show(input string tag);
    for (int i = 0; i < 400 && code_valid !== 1'b1; i++) @(negedge clk);
    check(tag, 32'(code_valid), 32'd1);
  endtask

  logic [4:0] exp_codes [3];
  logic [3:0] exp_digs  [3];

  initial begin
    reset   = 1'b1;
    digit   = 4'd0;
    ready   = 1'b0;
    key     = 4'd0;
    start   = 1'b0;
    enc_ack = 1'b0;
    enc_code = 5'd0;
    @(negedge clk);

    // 1: ready held through reset produces no load
    ready = 1'b1;
    do_reset(3);
    repeat (2) @(negedge clk);
    check("rst_code_out", 32'(code_out), 32'h0A);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enc_req", 32'(enc_req), 32'd0);
    ready = 1'b0;
    @(negedge clk);

    // 2: 1,2,7 with key 5 -> 6,7,2
    press_ready(4'd1);
    press_ready(4'd2);
    press_ready(4'd7);
    check("load_count", 32'(count), 32'd3);
    press_start(4'd5);
    wait_show("t2_show");
    exp_digs[0] = 4'd6;  exp_digs[1] = 4'd7;  exp_digs[2] = 4'd2;
    exp_codes[0] = 5'b00110; exp_codes[1] = 5'b00111; exp_codes[2] = 5'b00010;
    check("t2_req_num", 32'(req_num), 32'd3);
    for (int i = 0; i < 3 && i < dig_q.size(); i++) check("t2_enc_digit", 32'(dig_q[i]), 32'(exp_digs[i]));
    for (int k = 0; k < 13; k++) begin
      check("t2_code_out", 32'(code_out), 32'(exp_codes[(k / 4) % 3]));
      @(negedge clk);
    end
    check("t2_err", 32'(err), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    press_start(4'd5);
    check("t2_clr_valid", 32'(code_valid), 32'd0);
    check("t2_clr_code", 32'(code_out), 32'h0A);
    check("t2_clr_count", 32'(count), 32'd0);

    // 3: overflow past DEPTH
    do_reset(1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) press_ready(4'd3);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_err", 32'(err), 32'd0);
    press_ready(4'd3);
    check("t3_ovf_count", 32'(count), 32'd4);
    check("t3_ovf_err", 32'(err), 32'd1);

    // 4: illegal digit, then illegal key
    do_reset(1);
    @(negedge clk);
    press_ready(4'd1);
    press_ready(4'hC);
    check("t4_bad_digit_count", 32'(count), 32'd1);
    check("t4_bad_digit_err", 32'(err), 32'd1);
    do_reset(1);
    @(negedge clk);
    press_ready(4'd2);
    press_start(4'hA);
    repeat (3) @(negedge clk);
    check("t4_bad_key_busy", 32'(busy), 32'd0);
    check("t4_bad_key_req", 32'(req_num), 32'd0);
    check("t4_bad_key_err", 32'(err), 32'd1);
    check("t4_bad_key_count", 32'(count), 32'd1);

    // 5: second request never acked -> timeout substitutes IDLE_CODE
    do_reset(1);
    drop_n = 2;
    @(negedge clk);
    press_ready(4'd1);
    press_ready(4'd2);
    press_ready(4'd7);
    press_start(4'd5);
    wait_show("t5_show");
    check("t5_req_num", 32'(req_num), 32'd3);
    for (int i = 0; i < 3 && i < dig_q.size(); i++) check("t5_enc_digit", 32'(dig_q[i]), 32'(exp_digs[i]));
    if (req_cyc.size() == 3) begin
      check("t5_ack_gap", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
      check("t5_timeout_gap", 32'(req_cyc[2] - req_cyc[1]), 32'd17);
    end
    check("t5_err", 32'(err), 32'd1);
    exp_codes[1] = 5'b01010;
    for (int k = 0; k < 12; k++) begin
      check("t5_code_out", 32'(code_out), 32'(exp_codes[(k / 4) % 3]));
      @(negedge clk);
    end

    // 6: reset during WAIT aborts; the late ack is ignored
    do_reset(1);
    @(negedge clk);
    press_ready(4'd4);
    key   = 4'd1;
    start = 1'b1;
    for (int i = 0; i < 10 && req_num == 0; i++) @(negedge clk);
    start = 1'b0;
    check("t6_req_seen", 32'(req_num), 32'd1);
    @(negedge clk);
    check("t6_in_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t6_abort_req", 32'(enc_req), 32'd0);
    check("t6_abort_count", 32'(count), 32'd0);
    check("t6_abort_code", 32'(code_out), 32'h0A);
    check("t6_abort_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("t6_late_busy", 32'(busy), 32'd0);
    check("t6_late_valid", 32'(code_valid), 32'd0);
    check("t6_late_code", 32'(code_out), 32'h0A);
    check("t6_late_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
